// File: rtl/cipher_control_encrypt_if.sv
// Control/data bundle for the SPECK128/128 encryption core: start, key and
// plaintext in; ciphertext, finished flag and round index out.
interface cipher_control_encrypt_if;
  logic         start;
  logic [127:0] key;
  logic [127:0] plaintext;
  logic [127:0] ciphertext;
  logic         finished;
  logic [4:0]   state_response;

  modport master (
    output start, key, plaintext,
    input  ciphertext, finished, state_response
  );

  modport slave (
    input  start, key, plaintext,
    output ciphertext, finished, state_response
  );
endinterface

// File: rtl/cipher_control_encrypt.sv
// Iterative SPECK128/128 encryptor: one round plus one key-schedule step per clock.
// Latency 32 cycles from the accepting edge (3 when SPECK_REDUCED_ROUNDS_EN is defined).
// No backpressure: start is ignored while rounds run; result and finished are sticky until restart.
module cipher_control_encrypt (
  input  logic                     clk,
  input  logic                     rst,
  cipher_control_encrypt_if.slave  bus
);

`ifdef SPECK_REDUCED_ROUNDS_EN
  localparam int unsigned ROUNDS = 3;
`else
  localparam int unsigned ROUNDS = 32;
`endif
  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t       state;
  state_t       state_nxt;
  logic         load;
  logic         step;
  logic         last;

  logic [63:0]  x;
  logic [63:0]  y;
  logic [63:0]  k;
  logic [63:0]  l;
  logic [4:0]   cnt;
  logic [63:0]  x_nxt;
  logic [63:0]  y_nxt;
  logic [63:0]  k_nxt;
  logic [63:0]  l_nxt;

  logic [127:0] ciphertext_q;
  logic         finished_q;

  function automatic logic [63:0] ror8(input logic [63:0] v);
    return {v[7:0], v[63:8]};
  endfunction

  function automatic logic [63:0] rol3(input logic [63:0] v);
    return {v[60:0], v[63:61]};
  endfunction

  // Round function and key schedule share the current round key k.
  always_comb begin
    x_nxt = (ror8(x) + y) ^ k;
    y_nxt = rol3(y) ^ x_nxt;
    l_nxt = (k + ror8(l)) ^ {59'd0, cnt};
    k_nxt = rol3(k) ^ l_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        step = 1'b1;
        if (cnt == LAST_ROUND) begin
          last      = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = ROUND;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x            <= '0;
      y            <= '0;
      k            <= '0;
      l            <= '0;
      cnt          <= '0;
      ciphertext_q <= '0;
      finished_q   <= 1'b0;
    end else if (load) begin
      x          <= bus.plaintext[127:64];
      y          <= bus.plaintext[63:0];
      l          <= bus.key[127:64];
      k          <= bus.key[63:0];
      cnt        <= '0;
      finished_q <= 1'b0;
    end else if (step) begin
      x   <= x_nxt;
      y   <= y_nxt;
      k   <= k_nxt;
      l   <= l_nxt;
      cnt <= cnt + 5'd1;
      // Capture straight from the round logic so the result lands on the completing edge.
      if (last) begin
        ciphertext_q <= {x_nxt, y_nxt};
        finished_q   <= 1'b1;
      end
    end
  end

  always_comb begin
    bus.state_response = 5'd0;
    case (state)
      ROUND:   bus.state_response = cnt;
      DONE:    bus.state_response = LAST_ROUND;
      default: bus.state_response = 5'd0;
    endcase
  end

  assign bus.ciphertext = ciphertext_q;
  assign bus.finished   = finished_q;

endmodule

// File: tb/tb_cipher_control_encrypt.sv
// Bench for cipher_control_encrypt: vector table with a reference SPECK model,
// scoreboard queue of expected ciphertexts, plus reset corner sequences.
module tb_cipher_control_encrypt;

`ifdef SPECK_REDUCED_ROUNDS_EN
  localparam int N = 3;
`else
  localparam int N = 32;
`endif

  typedef struct {
    logic [127:0] key;
    logic [127:0] pt;
    logic [127:0] exp;
    bit           hold;
    bit           jitter;
  } vec_t;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  logic [127:0] sb[$];
  vec_t vecs[4];

  cipher_control_encrypt_if bus();

  cipher_control_encrypt dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference formulation: encrypt round R(x,y,k) then key update R(l,k,i).
  function automatic logic [127:0] speck_model(input logic [127:0] key,
                                                input logic [127:0] pt,
                                                input int rounds);
    logic [63:0] a, b, xx, yy;
    b  = key[63:0];
    a  = key[127:64];
    xx = pt[127:64];
    yy = pt[63:0];
    for (int i = 0; i < rounds; i++) begin
      xx = {xx[7:0], xx[63:8]};
      xx = xx + yy;
      xx = xx ^ b;
      yy = {yy[60:0], yy[63:61]};
      yy = yy ^ xx;
      a  = {a[7:0], a[63:8]};
      a  = a + b;
      a  = a ^ 64'(i);
      b  = {b[60:0], b[63:61]};
      b  = b ^ a;
    end
    return {xx, yy};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ciphertext"}, bus.ciphertext, 128'd0);
    chk({tag, "_finished"}, 128'(bus.finished), 128'd0);
    chk({tag, "_state_response"}, 128'(bus.state_response), 128'd0);
  endtask

  // Starts one block, follows every round, and scores the result at completion.
  task automatic run_op(input vec_t v, input logic [127:0] prev_ct);
    logic [127:0] exp;
    bit           seen;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.key       = v.key;
    bus.plaintext = v.pt;
    sb.push_back(v.exp);
    @(posedge clk); #1;
    if (!v.hold) bus.start = 1'b0;
    for (int c = 0; c < N; c++) begin
      chk("round_index", 128'(bus.state_response), 128'(c));
      chk("finished_low_in_round", 128'(bus.finished), 128'd0);
      chk("ciphertext_held", bus.ciphertext, prev_ct);
      if (v.jitter) begin
        bus.key       = {$urandom, $urandom, $urandom, $urandom};
        bus.plaintext = {$urandom, $urandom, $urandom, $urandom};
      end
      @(posedge clk); #1;
    end
    bus.start = 1'b0;
    chk("finished_latency", 128'(bus.finished), 128'd1);
    chk("done_state_response", 128'(bus.state_response), 128'(N - 1));
    seen = bus.finished;
    for (int w = 0; w < 10 && !seen; w++) begin
      @(posedge clk); #1;
      seen = bus.finished;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL finished_timeout: finished never rose, required 1");
      if (sb.size() > 0) void'(sb.pop_front());
    end else if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: completion with no expected entry");
    end else begin
      exp = sb.pop_front();
      chk("ciphertext", bus.ciphertext, exp);
    end
  endtask

  initial begin
    errors         = 0;
    checks         = 0;
    bus.start      = 1'b0;
    bus.key        = '0;
    bus.plaintext  = '0;
    rst            = 1'b1;
    #2;
    chk_idle_outputs("power_on_reset");
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_idle_outputs("after_reset_release");

    vecs[0].key = 128'h0f0e0d0c0b0a0908_0706050403020100;
    vecs[0].pt  = 128'h6c61766975716520_7469206564616d20;
`ifdef SPECK_REDUCED_ROUNDS_EN
    vecs[0].exp = speck_model(vecs[0].key, vecs[0].pt, N);
`else
    vecs[0].exp = 128'ha65d985179783265_7860fedf5c570d18;
`endif
    vecs[0].hold   = 1'b0;
    vecs[0].jitter = 1'b0;

    vecs[1]        = vecs[0];
    vecs[1].hold   = 1'b1;
    vecs[1].jitter = 1'b1;

    vecs[2].key    = 128'h753778214125442A_472D4B6150645367;
    vecs[2].pt     = 128'he5b2862a6a7d27f3_cf1688b3fbc40c13;
    vecs[2].exp    = speck_model(vecs[2].key, vecs[2].pt, N);
    vecs[2].hold   = 1'b0;
    vecs[2].jitter = 1'b0;

    vecs[3].key    = {$urandom, $urandom, $urandom, $urandom};
    vecs[3].pt     = {$urandom, $urandom, $urandom, $urandom};
    vecs[3].exp    = speck_model(vecs[3].key, vecs[3].pt, N);
    vecs[3].hold   = 1'b1;
    vecs[3].jitter = 1'b0;

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i], (i == 0) ? 128'd0 : vecs[i-1].exp);
    end

    // Reset in the middle of an operation: nothing may complete afterwards.
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.key       = vecs[2].key;
    bus.plaintext = vecs[2].pt;
    sb.push_back(vecs[2].exp);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    chk("pre_abort_round", 128'(bus.state_response), 128'd10);
    #3;
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_op_reset");
    sb.delete();
    @(posedge clk); #1;
    chk_idle_outputs("reset_held");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < N + 2; c++) begin
      @(posedge clk); #1;
    end
    chk_idle_outputs("aborted_no_output");
    run_op(vecs[0], 128'd0);

    // Asynchronous reset from DONE, mid-cycle, with a valid result showing.
    @(posedge clk); #3;
    chk("done_before_reset", 128'(bus.finished), 128'd1);
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset_from_done");
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_idle_outputs("idle_after_reset");

    chk("scoreboard_drained", 128'(sb.size()), 128'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
